// File: rtl/window_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen_pkg
//  Description : Shared RGB565 field layout, tap numbering and packed channel
//                widths for the 3x3 window generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package window_gen_pkg;

    localparam int PIX_W = 16;
    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;

    localparam int WIN_DIM   = 3;
    localparam int TAP_COUNT = WIN_DIM * WIN_DIM;

    localparam int R_PACKED_W = R_W * TAP_COUNT;
    localparam int G_PACKED_W = G_W * TAP_COUNT;
    localparam int B_PACKED_W = B_W * TAP_COUNT;

    // Row 0 is the oldest line, column 0 the oldest pixel.
    localparam int TAP_TOP_LEFT     = 0;
    localparam int TAP_CENTRE       = 4;
    localparam int TAP_BOTTOM_RIGHT = 8;

    typedef struct packed {
        logic [R_W-1:0] r;
        logic [G_W-1:0] g;
        logic [B_W-1:0] b;
    } rgb565_t;

    function automatic int tap_index(input int row, input int col);
        return row * WIN_DIM + col;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : line_buffer
//  Description : Circular buffer giving a fixed DEPTH-sample delay; one write
//                and one read per enabled cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_ptr;

    // Read-before-write at the same slot: the word leaving is DEPTH samples old.
    assign o_dout = r_mem[r_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_en) begin
            r_ptr <= (r_ptr == AW'(DEPTH - 1)) ? '0 : r_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            r_mem[r_ptr] <= i_din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/window_gen_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : window_gen_3x3
//  Description : 3x3 sliding-window generator for an RGB565 raster stream.
//                Define WINDOW_GEN_COORD_EN to add win_x/win_y centre outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module window_gen_3x3
    import window_gen_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [PIX_W-1:0]              pix_in,
    input  logic                          pix_valid,
    input  logic                          frame_start,
    output logic [R_PACKED_W-1:0]         r_channel,
    output logic [G_PACKED_W-1:0]         g_channel,
    output logic [B_PACKED_W-1:0]         b_channel,
    output logic                          win_valid
`ifdef WINDOW_GEN_COORD_EN
    ,
    output logic [$clog2(IMG_WIDTH)-1:0]  win_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] win_y
`endif
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [PIX_W-1:0]      w_line1;
    logic [PIX_W-1:0]      w_line2;
    rgb565_t               r_win     [TAP_COUNT];
    rgb565_t               w_win_nxt [TAP_COUNT];
    logic [COL_W-1:0]      r_col;
    logic [ROW_W-1:0]      r_row;
    logic [COL_W-1:0]      w_col_cur;
    logic [ROW_W-1:0]      w_row_cur;
    logic                  w_col_last;
    logic                  w_row_last;
    logic                  w_fire;
    logic [R_PACKED_W-1:0] w_r_pack;
    logic [G_PACKED_W-1:0] w_g_pack;
    logic [B_PACKED_W-1:0] w_b_pack;
    logic [R_PACKED_W-1:0] r_r_taps;
    logic [G_PACKED_W-1:0] r_g_taps;
    logic [B_PACKED_W-1:0] r_b_taps;
    logic                  r_win_valid;

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_line1 (
        .clk    (clk),
        .reset  (reset),
        .i_en   (pix_valid),
        .i_din  (pix_in),
        .o_dout (w_line1)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_W)) u_line2 (
        .clk    (clk),
        .reset  (reset),
        .i_en   (pix_valid),
        .i_din  (w_line1),
        .o_dout (w_line2)
    );

    // frame_start on an accepted pixel overrides the counters for that pixel.
    assign w_col_cur  = (frame_start) ? '0 : r_col;
    assign w_row_cur  = (frame_start) ? '0 : r_row;
    assign w_col_last = (w_col_cur == COL_W'(IMG_WIDTH - 1));
    assign w_row_last = (w_row_cur == ROW_W'(IMG_HEIGHT - 1));
    assign w_fire     = pix_valid && (w_col_cur >= COL_W'(2)) && (w_row_cur >= ROW_W'(2));

    always_comb begin
        for (int row = 0; row < WIN_DIM; row++) begin
            w_win_nxt[tap_index(row, 0)] = r_win[tap_index(row, 1)];
            w_win_nxt[tap_index(row, 1)] = r_win[tap_index(row, 2)];
        end
        w_win_nxt[tap_index(0, 2)] = rgb565_t'(w_line2);
        w_win_nxt[tap_index(1, 2)] = rgb565_t'(w_line1);
        w_win_nxt[tap_index(2, 2)] = rgb565_t'(pix_in);
    end

    generate
        for (genvar t = 0; t < TAP_COUNT; t++) begin : g_pack
            assign w_r_pack[t*R_W +: R_W] = w_win_nxt[t].r;
            assign w_g_pack[t*G_W +: G_W] = w_win_nxt[t].g;
            assign w_b_pack[t*B_W +: B_W] = w_win_nxt[t].b;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < TAP_COUNT; t++) begin
                r_win[t] <= '0;
            end
            r_col       <= '0;
            r_row       <= '0;
            r_r_taps    <= '0;
            r_g_taps    <= '0;
            r_b_taps    <= '0;
            r_win_valid <= 1'b0;
        end else begin
            r_win_valid <= w_fire;
            if (pix_valid) begin
                for (int t = 0; t < TAP_COUNT; t++) begin
                    r_win[t] <= w_win_nxt[t];
                end
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= (w_row_last) ? '0 : w_row_cur + ROW_W'(1);
                end else begin
                    r_col <= w_col_cur + COL_W'(1);
                    r_row <= w_row_cur;
                end
            end
            if (w_fire) begin
                r_r_taps <= w_r_pack;
                r_g_taps <= w_g_pack;
                r_b_taps <= w_b_pack;
            end
        end
    end

    assign r_channel = r_r_taps;
    assign g_channel = r_g_taps;
    assign b_channel = r_b_taps;
    assign win_valid = r_win_valid;

`ifdef WINDOW_GEN_COORD_EN
    logic [COL_W-1:0] r_win_x;
    logic [ROW_W-1:0] r_win_y;

    // The newest pixel is the bottom-right tap, so the centre lags it by one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_win_x <= '0;
            r_win_y <= '0;
        end else if (w_fire) begin
            r_win_x <= w_col_cur - COL_W'(1);
            r_win_y <= w_row_cur - ROW_W'(1);
        end
    end

    assign win_x = r_win_x;
    assign win_y = r_win_y;
`endif

endmodule
`default_nettype wire
